fetch_unit: RTL and testbench

//   Instruction fetch stage feeding the decoder/controller. Owns the program counter,

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches 16-bit words from a synchronous RAM into
// an instruction register, and shares the RAM address port with datapath load/store traffic.
module fetch_unit #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [DATA_W-1:0] ir_out,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [ADDR_W-1:0] pc_out,
   input  logic              data_req,
   input  logic [ADDR_W-1:0] data_addr,
   output logic              data_grant,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              halted,
   output logic [CNT_W-1:0]  instr_count
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      HOLD,
      HALTED
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_irPc;
   logic [DATA_W-1:0] r_irOut;
   logic              r_irValid;
   logic              r_halted;
   logic [CNT_W-1:0]  r_instrCount;
   logic              w_redirectOk;
   logic              w_accept;
   logic              w_isHalt;
   logic              w_fetchCycle;

   assign w_redirectOk = redirect &&
                         ((r_state == ISSUE) || (r_state == WAIT) || (r_state == HOLD));
   assign w_accept     = (r_state == HOLD) && r_irValid && ir_ready;
   assign w_isHalt     = (r_irOut[DATA_W-1 -: 3] == 3'b111);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic; a redirect always restarts at ISSUE, even when it meets an accept
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE, HALTED: begin
            if (start) w_nextState = ISSUE;
         end
         ISSUE: begin
            if (w_redirectOk)   w_nextState = ISSUE;
            else if (!data_req) w_nextState = WAIT;
         end
         WAIT: begin
            if (w_redirectOk) w_nextState = ISSUE;
            else              w_nextState = HOLD;
         end
         HOLD: begin
            if (w_redirectOk)  w_nextState = ISSUE;
            else if (w_accept) w_nextState = w_isHalt ? HALTED : ISSUE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // RAM port arbitration: fetch owns the port only in WAIT and an uncontested ISSUE cycle
   always_comb begin
      w_fetchCycle = (r_state == WAIT) || ((r_state == ISSUE) && !data_req);
      mem_addr     = w_fetchCycle ? r_pc : data_addr;
      data_grant   = data_req && !w_fetchCycle;
   end

   // PC, instruction register and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= '0;
         r_irOut      <= '0;
         r_irPc       <= '0;
         r_irValid    <= 1'b0;
         r_halted     <= 1'b0;
         r_instrCount <= '0;
      end else begin
         case (r_state)
            IDLE, HALTED: begin
               if (start) begin
                  r_pc     <= start_pc;
                  r_halted <= 1'b0;
               end
            end
            WAIT: begin
               if (!redirect) begin
                  r_irOut   <= mem_rdata;
                  r_irPc    <= r_pc;
                  r_pc      <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                  r_irValid <= 1'b1;
               end
            end
            HOLD: begin
               if (w_accept) begin
                  r_irValid <= 1'b0;
                  if (r_instrCount != {CNT_W{1'b1}}) begin
                     r_instrCount <= r_instrCount + {{(CNT_W-1){1'b0}}, 1'b1};
                  end
                  if (!redirect && w_isHalt) r_halted <= 1'b1;
               end
            end
            default: ;
         endcase
         if (w_redirectOk) begin
            r_pc      <= redirect_pc;
            r_irValid <= 1'b0;
         end
      end
   end

   assign ir_out      = r_irOut;
   assign ir_pc       = r_irPc;
   assign ir_valid    = r_irValid;
   assign pc_out      = r_pc;
   assign halted      = r_halted;
   assign instr_count = r_instrCount;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a synchronous RAM model feeds the DUT and a
// scoreboard queue holds the {pc, instruction} pairs expected in the IR.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  start_pc;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic [15:0] ir_out;
   logic [7:0]  ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic [7:0]  pc_out;
   logic        data_req;
   logic [7:0]  data_addr;
   logic        data_grant;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata;
   logic        halted;
   logic [15:0] instr_count;

   typedef struct packed {
      logic [7:0]  pc;
      logic [15:0] instr;
   } exp_t;

   exp_t        sbQ[$];
   exp_t        e;
   logic [15:0] ram [256];
   int          errors = 0;
   int          checks = 0;
   int          expCount = 0;
   int          n;

   fetch_unit #(.ADDR_W(8), .DATA_W(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .pc_out(pc_out), .data_req(data_req), .data_addr(data_addr),
      .data_grant(data_grant), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .halted(halted), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM: data appears one cycle after the address
   always @(posedge clk) mem_rdata <= ram[mem_addr];

   task tick;
      @(posedge clk);
      #2;
   endtask

   task waitValid(output int cycles);
      cycles = 0;
      while (ir_valid !== 1'b1 && cycles < 20) begin
         tick;
         cycles++;
      end
   endtask

   task test_reset;
      rst = 1'b1; data_req = 1'b1; data_addr = 8'h55;
      #3;
      checks++; if (pc_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc: got %h want 00", pc_out); end
      checks++; if (ir_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_ir: got %h want 0000", ir_out); end
      checks++; if (ir_pc !== 8'h00) begin errors++; $display("[TB] FAIL reset_irpc: got %h want 00", ir_pc); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", ir_valid); end
      checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
      checks++; if (instr_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", instr_count); end
      checks++; if (data_grant !== 1'b1) begin errors++; $display("[TB] FAIL reset_grant: got %b want 1", data_grant); end
      checks++; if (mem_addr !== 8'h55) begin errors++; $display("[TB] FAIL reset_memaddr: got %h want 55", mem_addr); end
      tick; tick;
      rst = 1'b0; data_req = 1'b0; data_addr = 8'hA5;
      tick; tick;
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid: got %b want 0", ir_valid); end
   endtask

   task test_basic;
      start = 1'b1; start_pc = 8'h10; ir_ready = 1'b1;
      sbQ.push_back('{pc: 8'h10, instr: ram[8'h10]});
      tick;
      start = 1'b0;
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid1: got %b want 0", ir_valid); end
      tick;
      checks++; if (mem_addr !== 8'h10) begin errors++; $display("[TB] FAIL basic_fetchaddr: got %h want 10", mem_addr); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid2: got %b want 0", ir_valid); end
      tick;
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid3: got %b want 1", ir_valid); end
      e = sbQ.pop_front();
      checks++; if (ir_out !== e.instr) begin errors++; $display("[TB] FAIL basic_ir: got %h want %h", ir_out, e.instr); end
      checks++; if (ir_pc !== e.pc) begin errors++; $display("[TB] FAIL basic_irpc: got %h want %h", ir_pc, e.pc); end
      checks++; if (pc_out !== 8'h11) begin errors++; $display("[TB] FAIL basic_pc: got %h want 11", pc_out); end
      expCount++;
      tick;
      ir_ready = 1'b0;
      checks++; if (instr_count !== 16'(expCount)) begin errors++; $display("[TB] FAIL basic_count: got %0d want %0d", instr_count, expCount); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_consumed: got %b want 0", ir_valid); end
   endtask

   task test_stall;
      sbQ.push_back('{pc: 8'h11, instr: ram[8'h11]});
      waitValid(n);
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_timeout: got %b want 1", ir_valid); end
      e = sbQ.pop_front();
      checks++; if (ir_out !== e.instr) begin errors++; $display("[TB] FAIL stall_ir: got %h want %h", ir_out, e.instr); end
      checks++; if (ir_pc !== e.pc) begin errors++; $display("[TB] FAIL stall_irpc: got %h want %h", ir_pc, e.pc); end
      for (int i = 0; i < 5; i++) begin
         tick;
         checks++; if (ir_out !== e.instr || ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold%0d: got %h/%b want %h/1", i, ir_out, ir_valid, e.instr); end
         checks++; if (pc_out !== 8'h12) begin errors++; $display("[TB] FAIL stall_pc%0d: got %h want 12", i, pc_out); end
         checks++; if (mem_addr !== 8'hA5 || data_grant !== 1'b0) begin errors++; $display("[TB] FAIL stall_nofetch%0d: got %h/%b want a5/0", i, mem_addr, data_grant); end
      end
      ir_ready = 1'b1; expCount++;
      sbQ.push_back('{pc: 8'h12, instr: ram[8'h12]});
      tick;
      ir_ready = 1'b0;
      checks++; if (instr_count !== 16'(expCount)) begin errors++; $display("[TB] FAIL stall_count: got %0d want %0d", instr_count, expCount); end
      checks++; if (mem_addr !== 8'h12) begin errors++; $display("[TB] FAIL stall_refetch: got %h want 12", mem_addr); end
      waitValid(n);
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_timeout2: got %b want 1", ir_valid); end
      e = sbQ.pop_front();
      checks++; if (ir_out !== e.instr || ir_pc !== e.pc) begin errors++; $display("[TB] FAIL stall_next: got %h@%h want %h@%h", ir_out, ir_pc, e.instr, e.pc); end
   endtask

   task test_data_port;
      ir_ready = 1'b1; expCount++;
      tick;
      ir_ready = 1'b0;
      sbQ.push_back('{pc: 8'h13, instr: ram[8'h13]});
      data_req = 1'b1; data_addr = 8'h77;
      #1;
      checks++; if (data_grant !== 1'b1 || mem_addr !== 8'h77) begin errors++; $display("[TB] FAIL data_issue1: got %b/%h want 1/77", data_grant, mem_addr); end
      tick;
      checks++; if (data_grant !== 1'b1 || mem_addr !== 8'h77) begin errors++; $display("[TB] FAIL data_issue2: got %b/%h want 1/77", data_grant, mem_addr); end
      tick;
      data_req = 1'b0;
      #1;
      checks++; if (data_grant !== 1'b0 || mem_addr !== 8'h13) begin errors++; $display("[TB] FAIL data_fetch: got %b/%h want 0/13", data_grant, mem_addr); end
      tick;
      data_req = 1'b1;
      #1;
      checks++; if (data_grant !== 1'b0 || mem_addr !== 8'h13) begin errors++; $display("[TB] FAIL data_wait: got %b/%h want 0/13", data_grant, mem_addr); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL data_delay: got %b want 0", ir_valid); end
      tick;
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL data_valid: got %b want 1", ir_valid); end
      checks++; if (data_grant !== 1'b1 || mem_addr !== 8'h77) begin errors++; $display("[TB] FAIL data_hold: got %b/%h want 1/77", data_grant, mem_addr); end
      e = sbQ.pop_front();
      checks++; if (ir_out !== e.instr || ir_pc !== e.pc) begin errors++; $display("[TB] FAIL data_ir: got %h@%h want %h@%h", ir_out, ir_pc, e.instr, e.pc); end
      checks++; if (instr_count !== 16'(expCount)) begin errors++; $display("[TB] FAIL data_count: got %0d want %0d", instr_count, expCount); end
      data_req = 1'b0; data_addr = 8'hA5;
   endtask

   task test_redirect;
      ir_ready = 1'b1; expCount++;
      tick;
      ir_ready = 1'b0;
      tick;
      redirect = 1'b1; redirect_pc = 8'h40;
      tick;
      redirect = 1'b0;
      checks++; if (pc_out !== 8'h40 || ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_pc: got %h/%b want 40/0", pc_out, ir_valid); end
      checks++; if (instr_count !== 16'(expCount)) begin errors++; $display("[TB] FAIL redir_count: got %0d want %0d", instr_count, expCount); end
      sbQ.push_back('{pc: 8'h40, instr: ram[8'h40]});
      waitValid(n);
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL redir_timeout: got %b want 1", ir_valid); end
      e = sbQ.pop_front();
      checks++; if (ir_out !== e.instr || ir_pc !== e.pc) begin errors++; $display("[TB] FAIL redir_ir: got %h@%h want %h@%h", ir_out, ir_pc, e.instr, e.pc); end
      checks++; if (instr_count !== 16'(expCount)) begin errors++; $display("[TB] FAIL redir_count2: got %0d want %0d", instr_count, expCount); end
   endtask

   task test_wrap;
      ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'hFF; expCount++;
      tick;
      ir_ready = 1'b0; redirect = 1'b0;
      checks++; if (instr_count !== 16'(expCount) || pc_out !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_accredir: got %0d/%h want %0d/ff", instr_count, pc_out, expCount); end
      sbQ.push_back('{pc: 8'hFF, instr: ram[8'hFF]});
      waitValid(n);
      e = sbQ.pop_front();
      checks++; if (ir_valid !== 1'b1 || ir_out !== e.instr || ir_pc !== e.pc) begin errors++; $display("[TB] FAIL wrap_ff: got %h@%h want %h@%h", ir_out, ir_pc, e.instr, e.pc); end
      checks++; if (pc_out !== 8'h00) begin errors++; $display("[TB] FAIL wrap_pc: got %h want 00", pc_out); end
      ir_ready = 1'b1; expCount++;
      sbQ.push_back('{pc: 8'h00, instr: ram[8'h00]});
      tick;
      ir_ready = 1'b0;
      waitValid(n);
      e = sbQ.pop_front();
      checks++; if (ir_valid !== 1'b1 || ir_out !== e.instr || ir_pc !== e.pc) begin errors++; $display("[TB] FAIL wrap_00: got %h@%h want %h@%h", ir_out, ir_pc, e.instr, e.pc); end
   endtask

   task test_halt;
      ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'h20; expCount++;
      tick;
      ir_ready = 1'b0; redirect = 1'b0;
      sbQ.push_back('{pc: 8'h20, instr: 16'hE000});
      waitValid(n);
      e = sbQ.pop_front();
      checks++; if (ir_valid !== 1'b1 || ir_out !== e.instr || ir_pc !== e.pc) begin errors++; $display("[TB] FAIL halt_ir: got %h@%h want %h@%h", ir_out, ir_pc, e.instr, e.pc); end
      ir_ready = 1'b1; expCount++;
      tick;
      ir_ready = 1'b0;
      checks++; if (halted !== 1'b1 || ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_flag: got %b/%b want 1/0", halted, ir_valid); end
      checks++; if (instr_count !== 16'(expCount) || pc_out !== 8'h21) begin errors++; $display("[TB] FAIL halt_state: got %0d/%h want %0d/21", instr_count, pc_out, expCount); end
      redirect = 1'b1; redirect_pc = 8'h50;
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++; if (mem_addr !== 8'hA5 || ir_valid !== 1'b0 || pc_out !== 8'h21) begin errors++; $display("[TB] FAIL halt_idle%0d: got %h/%b/%h want a5/0/21", i, mem_addr, ir_valid, pc_out); end
      end
      redirect = 1'b0;
      start = 1'b1; start_pc = 8'h30;
      tick;
      start = 1'b0;
      checks++; if (halted !== 1'b0 || pc_out !== 8'h30) begin errors++; $display("[TB] FAIL halt_restart: got %b/%h want 0/30", halted, pc_out); end
      sbQ.push_back('{pc: 8'h30, instr: ram[8'h30]});
      waitValid(n);
      e = sbQ.pop_front();
      checks++; if (ir_valid !== 1'b1 || ir_out !== e.instr || ir_pc !== e.pc) begin errors++; $display("[TB] FAIL halt_resume: got %h@%h want %h@%h", ir_out, ir_pc, e.instr, e.pc); end
   endtask

   task test_reset_midflight;
      ir_ready = 1'b1;
      tick;
      ir_ready = 1'b0;
      tick;
      checks++; if (mem_addr !== 8'h31 || data_grant !== 1'b0) begin errors++; $display("[TB] FAIL mid_wait: got %h/%b want 31/0", mem_addr, data_grant); end
      rst = 1'b1; data_req = 1'b1; data_addr = 8'h66;
      #1;
      checks++; if (pc_out !== 8'h00 || ir_out !== 16'h0000 || ir_pc !== 8'h00) begin errors++; $display("[TB] FAIL mid_regs: got %h/%h/%h want 00/0000/00", pc_out, ir_out, ir_pc); end
      checks++; if (ir_valid !== 1'b0 || halted !== 1'b0 || instr_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_flags: got %b/%b/%0d want 0/0/0", ir_valid, halted, instr_count); end
      checks++; if (data_grant !== 1'b1 || mem_addr !== 8'h66) begin errors++; $display("[TB] FAIL mid_port: got %b/%h want 1/66", data_grant, mem_addr); end
      tick;
      rst = 1'b0; data_req = 1'b0; data_addr = 8'hA5;
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++; if (ir_valid !== 1'b0 || pc_out !== 8'h00 || mem_addr !== 8'hA5) begin errors++; $display("[TB] FAIL mid_idle%0d: got %b/%h/%h want 0/00/a5", i, ir_valid, pc_out, mem_addr); end
      end
   endtask

   task test_back_to_back;
      start = 1'b1; start_pc = 8'h50; ir_ready = 1'b1;
      for (int k = 0; k < 3; k++) sbQ.push_back('{pc: 8'(8'h50 + k), instr: ram[8'h50 + k]});
      for (int k = 0; k < 3; k++) begin
         tick;
         start = 1'b0;
         n = 1;
         while (ir_valid !== 1'b1 && n < 20) begin tick; n++; end
         if (k == 2) ir_ready = 1'b0;
         checks++; if (n !== 3) begin errors++; $display("[TB] FAIL b2b_spacing%0d: got %0d cycles want 3", k, n); end
         e = sbQ.pop_front();
         checks++; if (ir_out !== e.instr || ir_pc !== e.pc) begin errors++; $display("[TB] FAIL b2b_ir%0d: got %h@%h want %h@%h", k, ir_out, ir_pc, e.instr, e.pc); end
      end
      tick;
      checks++; if (instr_count !== 16'd2 || ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_count: got %0d/%b want 2/1", instr_count, ir_valid); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 16'h0100 + 16'(i);
      ram[8'h10] = 16'hD105;
      ram[8'h20] = 16'hE000;
      start = 1'b0; start_pc = 8'h00; redirect = 1'b0; redirect_pc = 8'h00;
      ir_ready = 1'b0; data_req = 1'b0; data_addr = 8'h00;
      test_reset;
      test_basic;
      test_stall;
      test_data_port;
      test_redirect;
      test_wrap;
      test_halt;
      test_reset_midflight;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
